// File: rtl/page_flip_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : page_flip_ctrl_if
// Brief   : Request/frame-sync inputs and page/address outputs of page_flip_ctrl
// Revision: 1.0
// ============================================================================
interface page_flip_ctrl_if;
    logic        iVSYNC;
    logic        iNEXT_REQ;
    logic        iPREV_REQ;
    logic        iAUTO_EN;
    logic [22:0] oRD_ADDR;
    logic [1:0]  oPAGE_INDEX;
    logic        oFACTOR_RSTN;
    logic        oFLIP_DONE;
    logic        oBUSY;

    modport master (
        output iVSYNC, iNEXT_REQ, iPREV_REQ, iAUTO_EN,
        input  oRD_ADDR, oPAGE_INDEX, oFACTOR_RSTN, oFLIP_DONE, oBUSY
    );

    modport slave (
        input  iVSYNC, iNEXT_REQ, iPREV_REQ, iAUTO_EN,
        output oRD_ADDR, oPAGE_INDEX, oFACTOR_RSTN, oFLIP_DONE, oBUSY
    );
endinterface
`default_nettype wire

// File: rtl/page_flip_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : page_flip_ctrl
// Brief   : Applies photo-page flips only at frame start; drives read base.
// Revision: 1.0
// ============================================================================
module page_flip_ctrl #(
    parameter int          NUM_PAGES    = 3,
    parameter logic [18:0] BUFFER_SIZE  = 19'h5DC00,
    parameter int          RESET_PAGE   = 1,
    parameter int          SLIDE_FRAMES = 300,
    parameter int          HOLD_FRAMES  = 2
) (
    input  wire logic          iCLK,
    input  wire logic          iRST,
    page_flip_ctrl_if.slave    bus
);
    localparam logic [1:0]  c_last_page  = 2'(NUM_PAGES - 1);
    localparam logic [1:0]  c_reset_page = 2'(RESET_PAGE);
    localparam logic [22:0] c_stride     = {4'b0, BUFFER_SIZE};
    localparam logic [22:0] c_reset_addr = 23'(RESET_PAGE * int'(BUFFER_SIZE));
    localparam int          c_sw         = $clog2(SLIDE_FRAMES + 1);
    localparam int          c_hw         = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_FLIP    = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_vs_q, r_vs_qq;
    logic [1:0]        r_page, w_page_nx;
    logic [22:0]       r_addr, w_addr_nx;
    logic [1:0]        r_tgt, w_tgt_nx;
    logic [22:0]       r_tgt_addr, w_tgt_addr_nx;
    logic [c_sw-1:0]   r_slide_cnt, w_slide_nx;
    logic [c_hw-1:0]   r_hold_cnt, w_hold_nx;

    logic w_fs, w_next, w_prev, w_next_ok, w_prev_ok, w_auto;

    assign w_fs = r_vs_q & ~r_vs_qq;
    assign w_next = bus.iNEXT_REQ & ~bus.iPREV_REQ;
    assign w_prev = bus.iPREV_REQ & ~bus.iNEXT_REQ;
    // Manual requests are judged against the pending target, which equals the
    // current page whenever the controller is idle.
    assign w_next_ok = w_next && (r_tgt != c_last_page);
    assign w_prev_ok = w_prev && (r_tgt != 2'd0);
    assign w_auto    = bus.iAUTO_EN && (r_slide_cnt == c_sw'(SLIDE_FRAMES));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_vs_q      <= 1'b0;
            r_vs_qq     <= 1'b0;
            r_page      <= c_reset_page;
            r_addr      <= c_reset_addr;
            r_tgt       <= c_reset_page;
            r_tgt_addr  <= c_reset_addr;
            r_slide_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_vs_q      <= bus.iVSYNC;
            r_vs_qq     <= r_vs_q;
            r_page      <= w_page_nx;
            r_addr      <= w_addr_nx;
            r_tgt       <= w_tgt_nx;
            r_tgt_addr  <= w_tgt_addr_nx;
            r_slide_cnt <= w_slide_nx;
            r_hold_cnt  <= w_hold_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_page_nx     = r_page;
        w_addr_nx     = r_addr;
        w_tgt_nx      = r_tgt;
        w_tgt_addr_nx = r_tgt_addr;
        w_hold_nx     = r_hold_cnt;
        w_slide_nx    = r_slide_cnt;

        if (!bus.iAUTO_EN) begin
            w_slide_nx = '0;
        end else if ((r_state == S_IDLE) && w_fs) begin
            w_slide_nx = r_slide_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_next_ok) begin
                    w_tgt_nx      = r_tgt + 2'd1;
                    w_tgt_addr_nx = r_tgt_addr + c_stride;
                    w_slide_nx    = '0;
                    w_state_nx    = S_PENDING;
                end else if (w_prev_ok) begin
                    w_tgt_nx      = r_tgt - 2'd1;
                    w_tgt_addr_nx = r_tgt_addr - c_stride;
                    w_slide_nx    = '0;
                    w_state_nx    = S_PENDING;
                end else if (w_auto) begin
                    if (r_page == c_last_page) begin
                        w_tgt_nx      = 2'd0;
                        w_tgt_addr_nx = '0;
                    end else begin
                        w_tgt_nx      = r_tgt + 2'd1;
                        w_tgt_addr_nx = r_tgt_addr + c_stride;
                    end
                    w_slide_nx = '0;
                    w_state_nx = S_PENDING;
                end
            end
            S_PENDING: begin
                if (w_next_ok || w_prev_ok) begin
                    w_tgt_nx      = w_next_ok ? r_tgt + 2'd1 : r_tgt - 2'd1;
                    w_tgt_addr_nx = w_next_ok ? r_tgt_addr + c_stride
                                              : r_tgt_addr - c_stride;
                    w_slide_nx    = '0;
                end
                // A request that lands back on the displayed page cancels the flip.
                if ((w_next_ok || w_prev_ok) && (w_tgt_nx == r_page)) begin
                    w_state_nx = S_IDLE;
                end else if (w_fs) begin
                    w_state_nx = S_FLIP;
                end
            end
            S_FLIP: begin
                w_page_nx  = r_tgt;
                w_addr_nx  = r_tgt_addr;
                w_hold_nx  = '0;
                w_slide_nx = '0;
                w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (w_fs) begin
                    if (r_hold_cnt == c_hw'(HOLD_FRAMES - 1)) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_hold_nx = r_hold_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign bus.oRD_ADDR     = r_addr;
    assign bus.oPAGE_INDEX  = r_page;
    assign bus.oFACTOR_RSTN = (r_state != S_FLIP);
    assign bus.oFLIP_DONE   = (r_state == S_FLIP);
    assign bus.oBUSY        = (r_state == S_PENDING) || (r_state == S_HOLD);
endmodule
`default_nettype wire

// File: tb/tb_page_flip_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_page_flip_ctrl
// Brief   : Directed self-checking bench for page_flip_ctrl (SLIDE_FRAMES=4).
// Revision: 1.0
// ============================================================================
module tb_page_flip_ctrl;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   flips    = 0;

    page_flip_ctrl_if bus();

    page_flip_ctrl #(.SLIDE_FRAMES(4)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.oFLIP_DONE === 1'b1) flips++;

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        bus.iVSYNC = 1'b1; cyc();
        bus.iVSYNC = 1'b0; cyc();
    endtask

    task automatic pulse(input logic nxt, input logic prv);
        bus.iNEXT_REQ = nxt; bus.iPREV_REQ = prv; cyc();
        bus.iNEXT_REQ = 1'b0; bus.iPREV_REQ = 1'b0;
    endtask

    // Full flip: request, frame start, FLIP cycle, then two HOLD frame starts.
    task automatic do_flip(input logic nxt);
        pulse(nxt, ~nxt); frame(); cyc(); frame(); frame();
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(2);
        checks++; if (bus.oPAGE_INDEX !== 2'd1) begin failures++; $display("FAIL reset_page got=%0d exp=1", bus.oPAGE_INDEX); end
        checks++; if (bus.oRD_ADDR !== 23'h05DC00) begin failures++; $display("FAIL reset_addr got=%h exp=05dc00", bus.oRD_ADDR); end
        checks++; if (bus.oFACTOR_RSTN !== 1'b1) begin failures++; $display("FAIL reset_rstn got=%b exp=1", bus.oFACTOR_RSTN); end
        checks++; if (bus.oFLIP_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.oFLIP_DONE); end
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.oBUSY); end
        rst = 1'b0; cyc(2);
    endtask

    task automatic test_next_flip();
        pulse(1'b1, 1'b0);
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL next_pending got=%b exp=1", bus.oBUSY); end
        cyc(99);
        checks++; if (bus.oRD_ADDR !== 23'h05DC00) begin failures++; $display("FAIL next_before_vs got=%h exp=05dc00", bus.oRD_ADDR); end
        frame();
        checks++; if ({bus.oFLIP_DONE, bus.oFACTOR_RSTN} !== 2'b10) begin failures++; $display("FAIL next_pulse got=%b exp=10", {bus.oFLIP_DONE, bus.oFACTOR_RSTN}); end
        checks++; if (bus.oPAGE_INDEX !== 2'd1) begin failures++; $display("FAIL next_page_in_flip got=%0d exp=1", bus.oPAGE_INDEX); end
        cyc();
        checks++; if (bus.oRD_ADDR !== 23'h0BB800) begin failures++; $display("FAIL next_addr got=%h exp=0bb800", bus.oRD_ADDR); end
        checks++; if (bus.oPAGE_INDEX !== 2'd2) begin failures++; $display("FAIL next_page got=%0d exp=2", bus.oPAGE_INDEX); end
        checks++; if ({bus.oFLIP_DONE, bus.oFACTOR_RSTN, bus.oBUSY} !== 3'b011) begin failures++; $display("FAIL next_after_pulse got=%b exp=011", {bus.oFLIP_DONE, bus.oFACTOR_RSTN, bus.oBUSY}); end
        frame();
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL hold_mid got=%b exp=1", bus.oBUSY); end
        frame();
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL hold_end got=%b exp=0", bus.oBUSY); end
    endtask

    task automatic test_reject();
        int f0;
        f0 = flips;
        pulse(1'b1, 1'b0);
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL reject_next_busy got=%b exp=0", bus.oBUSY); end
        frame(); cyc();
        checks++; if (bus.oPAGE_INDEX !== 2'd2 || flips != f0) begin failures++; $display("FAIL reject_next_page got=%0d flips=%0d exp=2 flips=%0d", bus.oPAGE_INDEX, flips, f0); end
        do_flip(1'b0); do_flip(1'b0);
        checks++; if (bus.oRD_ADDR !== 23'h0 || bus.oPAGE_INDEX !== 2'd0) begin failures++; $display("FAIL prev_to_zero got=%h/%0d exp=0/0", bus.oRD_ADDR, bus.oPAGE_INDEX); end
        pulse(1'b0, 1'b1);
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL reject_prev_busy got=%b exp=0", bus.oBUSY); end
    endtask

    task automatic test_cancel();
        int f0;
        pulse(1'b1, 1'b1);
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL both_busy got=%b exp=0", bus.oBUSY); end
        do_flip(1'b1);
        checks++; if (bus.oPAGE_INDEX !== 2'd1 || bus.oRD_ADDR !== 23'h05DC00) begin failures++; $display("FAIL to_page1 got=%0d/%h exp=1/05dc00", bus.oPAGE_INDEX, bus.oRD_ADDR); end
        f0 = flips;
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", bus.oBUSY); end
        frame(); cyc(); frame();
        checks++; if (bus.oPAGE_INDEX !== 2'd1 || flips != f0) begin failures++; $display("FAIL cancel_noflip got=%0d flips=%0d exp=1 flips=%0d", bus.oPAGE_INDEX, flips, f0); end
    endtask

    task automatic test_auto_wrap();
        do_flip(1'b1);
        bus.iAUTO_EN = 1'b1; cyc();
        repeat (4) frame();
        checks++; if (bus.oPAGE_INDEX !== 2'd2 || bus.oBUSY !== 1'b0) begin failures++; $display("FAIL auto_4frames got=%0d/%b exp=2/0", bus.oPAGE_INDEX, bus.oBUSY); end
        cyc();
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL auto_pending got=%b exp=1", bus.oBUSY); end
        frame();
        checks++; if (bus.oFLIP_DONE !== 1'b1) begin failures++; $display("FAIL auto_done got=%b exp=1", bus.oFLIP_DONE); end
        cyc();
        checks++; if (bus.oPAGE_INDEX !== 2'd0 || bus.oRD_ADDR !== 23'h0) begin failures++; $display("FAIL auto_wrap got=%0d/%h exp=0/0", bus.oPAGE_INDEX, bus.oRD_ADDR); end
        pulse(1'b1, 1'b0);
        frame(); frame();
        bus.iAUTO_EN = 1'b0; cyc();
        checks++; if (bus.oBUSY !== 1'b0) begin failures++; $display("FAIL hold_drop_busy got=%b exp=0", bus.oBUSY); end
        frame(); cyc();
        checks++; if (bus.oPAGE_INDEX !== 2'd0) begin failures++; $display("FAIL hold_drop_page got=%0d exp=0", bus.oPAGE_INDEX); end
    endtask

    task automatic test_reset_pending();
        int f0;
        pulse(1'b1, 1'b0);
        checks++; if (bus.oBUSY !== 1'b1) begin failures++; $display("FAIL rp_pending got=%b exp=1", bus.oBUSY); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.oPAGE_INDEX !== 2'd1 || bus.oRD_ADDR !== 23'h05DC00 || bus.oBUSY !== 1'b0) begin failures++; $display("FAIL rp_async got=%0d/%h/%b exp=1/05dc00/0", bus.oPAGE_INDEX, bus.oRD_ADDR, bus.oBUSY); end
        cyc(2); rst = 1'b0;
        f0 = flips;
        frame(); cyc(); frame(); cyc();
        checks++; if (bus.oPAGE_INDEX !== 2'd1 || flips != f0 || bus.oBUSY !== 1'b0) begin failures++; $display("FAIL rp_noflip got=%0d flips=%0d busy=%b exp=1 flips=%0d busy=0", bus.oPAGE_INDEX, flips, bus.oBUSY, f0); end
    endtask

    initial begin
        rst = 1'b1;
        bus.iVSYNC = 1'b0; bus.iNEXT_REQ = 1'b0; bus.iPREV_REQ = 1'b0; bus.iAUTO_EN = 1'b0;
        test_reset();
        test_next_flip();
        test_reject();
        test_cancel();
        test_auto_wrap();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
